// File: rtl/counter_ultra_pkg.sv
// Shared types and constants for the counter_ultra display/mode path.
package counter_ultra_pkg;

  typedef enum logic [2:0] {
    SW    = 3'd0,
    SW2CD = 3'd1,
    CD    = 3'd2,
    CD2SW = 3'd3,
    ALARM = 3'd4
  } mode_state_e;

  // Countdown engine button pulses, one bit per button.
  typedef struct packed {
    logic left;
    logic right;
    logic center;
    logic up;
    logic down;
  } cd_btn_t;

  localparam logic [1:0] FLICK_NONE     = 2'b11;
  localparam logic       DISP_STOPWATCH = 1'b0;
  localparam logic       DISP_COUNTDOWN = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a raw asynchronous level; synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mode_controller.sv
// Sequences stopwatch/countdown engines behind one display: blanked switchover,
// button routing, and countdown-expiry alarm. Optional macro: ALARM_TIMEOUT_EN.
module mode_controller
  import counter_ultra_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 20,
  parameter int unsigned ALARM_CYCLES = 500,
  parameter int unsigned BLINK_HALF   = 25
) (
  input  logic       clk_core,
  input  logic       rst_n,
  input  logic       mode_switch,
  input  logic       left_p,
  input  logic       right_p,
  input  logic       center_p,
  input  logic       up_p,
  input  logic       down_p,
  input  logic       time_out_i,
  input  logic [1:0] target_i,
  output logic       sw_rst_o,
  output logic       sw_pause_o,
  output logic       sw_record_o,
  output logic       cd_left_o,
  output logic       cd_right_o,
  output logic       cd_center_o,
  output logic       cd_up_o,
  output logic       cd_down_o,
  output logic       disp_sel_o,
  output logic       blank_o,
  output logic [1:0] flick_o,
  output logic       alarm_o
);

  localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

  if (BLANK_CYCLES < 1 || BLINK_HALF < 1 || ALARM_CYCLES < 1) begin : g_param_check
    $error("mode_controller: cycle parameters must be >= 1");
  end

  mode_state_e        state_q, state_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               to_prev_q;
  logic [2:0]         sw_q, sw_d;
  cd_btn_t            cd_q, cd_d;
  logic               disp_q, disp_d;
  logic               blank_q, blank_d;
  logic               alarm_q, alarm_d;
  logic               msync;
  logic               btn_any;
  logic               to_rise;
  logic               alarm_expired;

  sync_2ff u_mode_sync (
    .clk   (clk_core),
    .rst_n (rst_n),
    .d     (mode_switch),
    .q     (msync)
  );

`ifdef ALARM_TIMEOUT_EN
  localparam int unsigned ALARM_W = $clog2(ALARM_CYCLES + 1);
  logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;

  // Held preloaded outside ALARM so it starts at ALARM_CYCLES-1 on entry.
  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if (state_q != ALARM) begin
      alarm_cnt_d = ALARM_W'(ALARM_CYCLES - 1);
    end else if (alarm_cnt_q != '0) begin
      alarm_cnt_d = alarm_cnt_q - ALARM_W'(1);
    end
  end

  always_ff @(posedge clk_core) begin
    if (!rst_n) alarm_cnt_q <= '0;
    else        alarm_cnt_q <= alarm_cnt_d;
  end

  assign alarm_expired = (state_q == ALARM) && (alarm_cnt_q == '0);
`else
  assign alarm_expired = 1'b0;
`endif

  assign btn_any = left_p | right_p | center_p | up_p | down_p;
  assign to_rise = time_out_i & ~to_prev_q;

  // Next state; mode change outranks alarm entry and alarm acknowledge.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      SW: if (msync) begin
        state_d     = SW2CD;
        blank_cnt_d = BLANK_W'(BLANK_CYCLES - 1);
      end
      SW2CD: if (blank_cnt_q == '0) state_d = CD;
             else blank_cnt_d = blank_cnt_q - BLANK_W'(1);
      CD: if (!msync) begin
        state_d     = CD2SW;
        blank_cnt_d = BLANK_W'(BLANK_CYCLES - 1);
      end else if (to_rise) begin
        state_d = ALARM;
      end
      CD2SW: if (blank_cnt_q == '0) state_d = SW;
             else blank_cnt_d = blank_cnt_q - BLANK_W'(1);
      ALARM: if (!msync) begin
        state_d     = CD2SW;
        blank_cnt_d = BLANK_W'(BLANK_CYCLES - 1);
      end else if (btn_any || alarm_expired) begin
        state_d = CD;
      end
      default: state_d = SW;
    endcase
  end

  // Registered outputs follow the next state; pulses pass only when the engine stays active.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blank_d     = 1'b0;
    disp_d      = (state_d == SW || state_d == CD2SW) ? DISP_STOPWATCH : DISP_COUNTDOWN;
    alarm_d     = (state_d == ALARM);
    if (state_d == SW2CD || state_d == CD2SW) begin
      blank_d = 1'b1;
    end else if (state_d == ALARM) begin
      if (state_q != ALARM) begin
        blink_cnt_d = BLINK_W'(BLINK_HALF - 1);
      end else if (blink_cnt_q == '0) begin
        blank_d     = ~blank_q;
        blink_cnt_d = BLINK_W'(BLINK_HALF - 1);
      end else begin
        blank_d     = blank_q;
        blink_cnt_d = blink_cnt_q - BLINK_W'(1);
      end
    end
    sw_d = {right_p, center_p, left_p} & {3{(state_q == SW) && (state_d == SW)}};
    cd_d = cd_btn_t'({left_p, right_p, center_p, up_p, down_p}
                     & {5{(state_q == CD) && (state_d == CD)}});
  end

  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      state_q     <= SW;
      blank_cnt_q <= '0;
      blink_cnt_q <= '0;
      to_prev_q   <= 1'b0;
      sw_q        <= '0;
      cd_q        <= '0;
      disp_q      <= DISP_STOPWATCH;
      blank_q     <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      to_prev_q   <= time_out_i;
      sw_q        <= sw_d;
      cd_q        <= cd_d;
      disp_q      <= disp_d;
      blank_q     <= blank_d;
      alarm_q     <= alarm_d;
    end
  end

  assign {sw_rst_o, sw_pause_o, sw_record_o} = sw_q;
  assign cd_left_o   = cd_q.left;
  assign cd_right_o  = cd_q.right;
  assign cd_center_o = cd_q.center;
  assign cd_up_o     = cd_q.up;
  assign cd_down_o   = cd_q.down;
  assign disp_sel_o  = disp_q;
  assign blank_o     = blank_q;
  assign alarm_o     = alarm_q;
  // Edit-field flick tracks target_i in the same cycle while countdown is active.
  assign flick_o     = (state_q == CD) ? target_i : FLICK_NONE;

endmodule

// File: doc/mode_controller.md
Name: mode_controller

Overview:
- Sequences the two timing engines (stopwatch counter_commander, countdown rcounter_commander) behind one display path, replacing the combinational mode mux and button gating in top.
- Synchronizes mode_switch and performs a blanked, glitch-free switchover.
- Routes debounced button pulses only to the active engine and selects the display source and flick field.
- Runs a countdown-expiry alarm sequence with acknowledge.

Parameters:
- BLANK_CYCLES, 20: clk_core cycles the display is blanked during a mode switchover (≥1).
- ALARM_CYCLES, 500: clk_core cycles the alarm lasts before auto-return. Used only with ALARM_TIMEOUT_EN.
- BLINK_HALF, 25: clk_core cycles per half-period of the alarm blank blink (≥1).

Ports:
- clk_core, input, 1: core clock; all state on rising edge.
- rst_n, input, 1: synchronous active-low reset.
- mode_switch, input, 1: raw slide switch; 0 = stopwatch, 1 = countdown. Asynchronous to clk_core.
- left_p / right_p / center_p / up_p / down_p, input, 1 each: debounced single-cycle button pulses.
- time_out_i, input, 1: countdown engine expiry level.
- target_i, input, 2: countdown engine edit-field select.
- sw_rst_o / sw_pause_o / sw_record_o, output, 1 each: stopwatch pulses, sourced from right / center / left.
- cd_left_o / cd_right_o / cd_center_o / cd_up_o / cd_down_o, output, 1 each: countdown pulses.
- disp_sel_o, output, 1: 0 = stopwatch digits, 1 = countdown digits.
- blank_o, output, 1: force all display segments off.
- flick_o, output, 2: flick field to both display drivers; 2'b11 = no flick.
- alarm_o, output, 1: alarm indicator/buzzer enable.

Behaviour:
- mode_switch passes through a 2-FF synchronizer; msync is its output. Sync flops reset to 0.
- States:
  - SW: stopwatch active.
  - SW2CD: switchover from stopwatch to countdown.
  - CD: countdown active.
  - CD2SW: switchover from countdown to stopwatch.
  - ALARM: countdown expired.
- Reset state is SW. Reset values of outputs:
  - every pulse output 0
  - disp_sel_o 0, blank_o 0, alarm_o 0
  - flick_o 2'b11
  - all counters 0
- Transitions:
  - SW: msync=1 → SW2CD, loading the blank counter with BLANK_CYCLES-1.
  - SW2CD: counter reaches 0 → CD.
  - CD: msync=0 → CD2SW. time_out_i rising edge (registered previous value) → ALARM.
  - CD2SW: counter reaches 0 → SW.
  - ALARM:
    - any button pulse → CD; the pulse is consumed, not forwarded.
    - msync=0 → CD2SW; takes priority over a button pulse.
- Transient states are not interruptible. If msync reverts mid-transition, the transition completes and the reverse transition starts the next cycle.
- Outputs per state:
  - SW: disp_sel_o 0, flick_o 2'b11, blank_o 0. Stopwatch pulses are registered copies of inputs, 1-cycle latency. up/down are ignored.
  - CD: disp_sel_o 1, flick_o = target_i (combinational), blank_o 0. Countdown pulses have 1-cycle latency.
  - SW2CD / CD2SW: blank_o 1. disp_sel_o already equals the destination. All pulse outputs 0; input pulses are dropped, not queued.
  - ALARM:
    - disp_sel_o 1, alarm_o 1, flick_o 2'b11, no pulses forwarded.
    - blank_o toggles every BLINK_HALF cycles, starting at 0 on entry.
- Both engines keep running in the background; this block never resets or pauses the inactive engine.
- Simultaneous events:
  - mode change detected in the same cycle as a button pulse: mode change wins, pulse dropped.
  - mode change and time_out edge in CD in the same cycle: mode change wins, no alarm.
- time_out_i held high after ALARM exit does not re-trigger; only a fresh 0→1 edge does.
- Reset asserted mid-transition or mid-alarm: outputs return to reset values on the next edge. If the switch is at 1, SW2CD begins 2 cycles after release.

Optional Feature:
- ALARM_TIMEOUT_EN defined: an alarm cycle counter loads ALARM_CYCLES-1 on ALARM entry. ALARM → CD when it reaches 0 (same cycle as a button pulse: go to CD once, pulse consumed).
- ALARM_TIMEOUT_EN undefined: ALARM persists until a button pulse or msync=0. The counter and parameter are unused.

Decomposition:
- Package counter_ultra_pkg holds:
  - state enum {SW, SW2CD, CD, CD2SW, ALARM}
  - FLICK_NONE = 2'b11
  - DISP_STOPWATCH = 1'b0, DISP_COUNTDOWN = 1'b1
- Sub-module sync_2ff: 2-flop synchronizer with synchronous active-low reset, reusable for other raw switches.

Test Plan:
- Reset, mode_switch=0, pulse right_p → sw_rst_o high exactly 1 cycle, 1 cycle later; cd_* stay 0; flick_o=2'b11.
- mode_switch 0→1 with BLANK_CYCLES=20 → disp_sel_o=1 and blank_o=1 for exactly 20 cycles after sync (2-cycle delay); up_p pulsed mid-window not forwarded; afterwards up_p → cd_up_o.
- In CD, target_i=2'b01 → flick_o=2'b01 the same cycle; switch back → flick_o=2'b11 and disp_sel_o=0 from CD2SW entry.
- In CD, raise time_out_i → alarm_o=1 next cycle, blank_o toggles every 25 cycles; center_p → back to CD, cd_center_o stays 0.
- With ALARM_TIMEOUT_EN and ALARM_CYCLES=500: no input → alarm_o drops after 500 cycles; without the macro, alarm_o still 1 at 1000 cycles.
- mode_switch→0 during ALARM in the same cycle as left_p → CD2SW, alarm_o=0, no pulse on any output; rst_n low mid-SW2CD → reset values next edge.
